// File: rtl/tick_pwm.sv
// Tick-driven PWM generator: period and duty counted in input ticks, with
// duty updates double-buffered so they only take effect at a period boundary.
module tick_pwm #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    output logic             duty_ack,
    output logic             pending,
    output logic             pwm_out,
    output logic             period_start
);

    generate
        if (PERIOD < 2 || PERIOD > (2 ** WIDTH) - 1) begin : g_bad_period
            $error("tick_pwm: PERIOD must be within 2 .. 2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] FULL = WIDTH'(PERIOD);

    // Any request at or above the period length saturates to 100% duty.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v >= FULL) ? FULL : v;
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] duty_sh;
    logic             wrap;

    assign wrap = tick_in && (cnt == LAST);

    // duty_wr is a fire-and-forget strobe with no ready: every write is
    // accepted, the last one before a boundary wins, and duty_ack echoes
    // each accepted write exactly one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            duty_act     <= '0;
            duty_sh      <= '0;
            pending      <= 1'b0;
            pwm_out      <= 1'b0;
            duty_ack     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= (cnt < duty_act);
            duty_ack     <= duty_wr;
            period_start <= wrap;

            if (tick_in) begin
                cnt <= wrap ? '0 : cnt + WIDTH'(1);
            end

            if (duty_wr) begin
                duty_sh <= duty_in;
            end

            // A write landing on the boundary bypasses the shadow entirely.
            if (wrap) begin
                pending <= 1'b0;
                if (duty_wr) begin
                    duty_act <= clamp(duty_in);
                end else if (pending) begin
                    duty_act <= clamp(duty_sh);
                end
            end else if (duty_wr) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_pwm.sv
// Bench for tick_pwm: per-period high/length measurements compared against
// tick arithmetic (duty x tick spacing) and a random-write scoreboard.
module tb_tick_pwm;

    localparam int W = 8;
    localparam int P = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick_in = 1'b0;
    logic         duty_wr = 1'b0;
    logic [W-1:0] duty_in = '0;
    logic         duty_ack;
    logic         pending;
    logic         pwm_out;
    logic         period_start;

    int tests_run = 0;
    int tests_failed = 0;

    int spacing = 5;
    int div_cnt = 0;
    int tick_total = 0;
    int ps_count = 0;
    int acc_hi = 0;
    int acc_len = 0;
    int acc_lead = 0;
    bit lead_open = 1'b1;
    bit timed_out = 1'b0;
    int meas_hi[$];
    int meas_len[$];
    int meas_lead[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    tick_pwm #(.WIDTH(W), .PERIOD(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .duty_in     (duty_in),
        .duty_wr     (duty_wr),
        .duty_ack    (duty_ack),
        .pending     (pending),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    // ---------------- driver / monitor ----------------
    task automatic step(input logic wr, input logic [W-1:0] din, input logic rst);
        logic t;
        t = (div_cnt == spacing - 1);
        tick_in = t;
        duty_wr = wr;
        duty_in = din;
        reset   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            div_cnt = 0; tick_total = 0;
            acc_hi = 0; acc_len = 0; acc_lead = 0; lead_open = 1'b1;
        end else begin
            if (t) begin tick_total++; div_cnt = 0; end else div_cnt++;
            acc_len++;
            if (pwm_out === 1'b1) begin
                acc_hi++;
                if (lead_open) acc_lead++;
            end else begin
                lead_open = 1'b0;
            end
            if (period_start === 1'b1) begin
                meas_hi.push_back(acc_hi);
                meas_len.push_back(acc_len);
                meas_lead.push_back(acc_lead);
                acc_hi = 0; acc_len = 0; acc_lead = 0; lead_open = 1'b1;
                ps_count++;
            end
        end
    endtask

    task automatic run_periods(input int n, input int budget);
        int target;
        int c;
        target = ps_count + n;
        c = 0;
        while (ps_count < target && c < budget) begin
            step(1'b0, '0, 1'b0);
            c++;
        end
        timed_out = (ps_count < target);
    endtask

    task automatic wait_phase(input int ph, input bit at_tick, input int budget);
        int c;
        c = 0;
        while (c < budget && !((tick_total % P) == ph && (!at_tick || div_cnt == spacing - 1))) begin
            step(1'b0, '0, 1'b0);
            c++;
        end
        timed_out = (c >= budget);
    endtask

    task automatic clear_meas();
        meas_hi.delete();
        meas_len.delete();
        meas_lead.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1'b1, 8'd50, 1'b1);
        step(1'b0, '0, 1'b1);
        tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        tests_run++; if (duty_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b want 0", duty_ack); end
        tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL reset_pending: got %b want 0", pending); end
        tests_run++; if (period_start !== 1'b0) begin tests_failed++; $display("FAIL reset_ps: got %b want 0", period_start); end
        step(1'b0, '0, 1'b0);
        tests_run++; if (duty_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_write_ignored: ack got %b want 0", duty_ack); end
    endtask

    task automatic test_basic_duty();
        spacing = 5;
        clear_meas();
        run_periods(1, 200);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL basic_first_wrap: timed out, got no period_start want one"); end
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 0) begin tests_failed++; $display("FAIL basic_low_after_reset: got %0d high want 0", meas_hi.size() ? meas_hi[0] : -1); end
        clear_meas();
        step(1'b1, 8'd3, 1'b0);
        tests_run++; if (duty_ack !== 1'b1) begin tests_failed++; $display("FAIL basic_ack: got %b want 1", duty_ack); end
        tests_run++; if (pending !== 1'b1) begin tests_failed++; $display("FAIL basic_pending: got %b want 1", pending); end
        step(1'b0, '0, 1'b0);
        tests_run++; if (duty_ack !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_once: got %b want 0", duty_ack); end
        run_periods(1, 100);
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 0) begin tests_failed++; $display("FAIL basic_old_period: got %0d high want 0", meas_hi.size() ? meas_hi[0] : -1); end
        step(1'b0, '0, 1'b0);
        tests_run++; if (period_start !== 1'b0) begin tests_failed++; $display("FAIL basic_ps_one_cycle: got %b want 0", period_start); end
        clear_meas();
        run_periods(3, 250);
        tests_run++; if (meas_hi.size() != 3) begin tests_failed++; $display("FAIL basic_count: got %0d periods want 3", meas_hi.size()); end
        foreach (meas_hi[i]) begin
            tests_run++; if (meas_hi[i] != 15 || meas_lead[i] != 15) begin tests_failed++; $display("FAIL basic_high[%0d]: got %0d (lead %0d) want 15", i, meas_hi[i], meas_lead[i]); end
            tests_run++; if (meas_len[i] != 50) begin tests_failed++; $display("FAIL basic_len[%0d]: got %0d want 50", i, meas_len[i]); end
        end
    endtask

    task automatic test_double_buffer();
        wait_phase(4, 1'b0, 100);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL dbuf_sync: timed out, phase got %0d want 4", tick_total % P); end
        clear_meas();
        step(1'b1, 8'd7, 1'b0);
        tests_run++; if (duty_ack !== 1'b1 || pending !== 1'b1) begin tests_failed++; $display("FAIL dbuf_write: ack/pending got %b%b want 11", duty_ack, pending); end
        step(1'b0, '0, 1'b0);
        tests_run++; if (duty_ack !== 1'b0 || pending !== 1'b1) begin tests_failed++; $display("FAIL dbuf_hold: ack/pending got %b%b want 01", duty_ack, pending); end
        run_periods(1, 100);
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 15) begin tests_failed++; $display("FAIL dbuf_current: got %0d high want 15", meas_hi.size() ? meas_hi[0] : -1); end
        tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL dbuf_pending_clear: got %b want 0", pending); end
        clear_meas();
        run_periods(1, 100);
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 35 || meas_lead[0] != 35) begin tests_failed++; $display("FAIL dbuf_next: got %0d high want 35", meas_hi.size() ? meas_hi[0] : -1); end
    endtask

    task automatic test_boundaries();
        int duties[4] = '{0, 10, 255, 1};
        int want;
        foreach (duties[k]) begin
            step(1'b1, W'(duties[k]), 1'b0);
            run_periods(1, 100);
            clear_meas();
            run_periods(2, 200);
            want = ((duties[k] > P) ? P : duties[k]) * spacing;
            tests_run++; if (meas_hi.size() != 2) begin tests_failed++; $display("FAIL bound_count d=%0d: got %0d periods want 2", duties[k], meas_hi.size()); end
            foreach (meas_hi[i]) begin
                tests_run++; if (meas_hi[i] != want || meas_lead[i] != want || meas_len[i] != 50) begin
                    tests_failed++; $display("FAIL bound d=%0d[%0d]: got high %0d len %0d want high %0d len 50", duties[k], i, meas_hi[i], meas_len[i], want);
                end
            end
        end
    endtask

    task automatic test_collisions();
        run_periods(1, 100);
        clear_meas();
        step(1'b1, 8'd5, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b1, 8'd8, 1'b0);
        run_periods(1, 100);
        clear_meas();
        run_periods(1, 100);
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 40) begin tests_failed++; $display("FAIL coll_last_wins: got %0d high want 40", meas_hi.size() ? meas_hi[0] : -1); end
        wait_phase(P - 1, 1'b1, 100);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL coll_sync: timed out before wrap cycle"); end
        step(1'b1, 8'd2, 1'b0);
        tests_run++; if (duty_ack !== 1'b1 || pending !== 1'b0 || period_start !== 1'b1) begin
            tests_failed++; $display("FAIL coll_wrap_write: ack/pending/ps got %b%b%b want 101", duty_ack, pending, period_start);
        end
        clear_meas();
        run_periods(1, 100);
        tests_run++; if (meas_hi.size() != 1 || meas_hi[0] != 10) begin tests_failed++; $display("FAIL coll_bypass: got %0d high want 10", meas_hi.size() ? meas_hi[0] : -1); end
        tests_run++; if (pending !== 1'b0) begin tests_failed++; $display("FAIL coll_pending: got %b want 0", pending); end
    endtask

    task automatic test_reset_fullrate();
        wait_phase(5, 1'b0, 100);
        step(1'b1, 8'd9, 1'b0);
        wait_phase(6, 1'b0, 100);
        tests_run++; if (timed_out || pending !== 1'b1) begin tests_failed++; $display("FAIL rst_setup: pending got %b want 1", pending); end
        step(1'b0, '0, 1'b1);
        tests_run++; if ({pwm_out, duty_ack, pending, period_start} !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_mid: pwm/ack/pend/ps got %b%b%b%b want 0000", pwm_out, duty_ack, pending, period_start);
        end
        spacing = 1;
        clear_meas();
        run_periods(2, 100);
        tests_run++; if (meas_hi.size() != 2 || meas_len[0] != 10) begin tests_failed++; $display("FAIL rst_cnt_zero: got len %0d want 10", meas_len.size() ? meas_len[0] : -1); end
        tests_run++; if (meas_hi.size() != 2 || meas_hi[0] != 0 || meas_hi[1] != 0) begin tests_failed++; $display("FAIL rst_write_lost: got nonzero high want 0"); end
        step(1'b1, 8'd4, 1'b0);
        run_periods(1, 50);
        clear_meas();
        run_periods(3, 100);
        tests_run++; if (meas_hi.size() != 3) begin tests_failed++; $display("FAIL full_count: got %0d periods want 3", meas_hi.size()); end
        foreach (meas_hi[i]) begin
            tests_run++; if (meas_hi[i] != 4 || meas_lead[i] != 4 || meas_len[i] != 10) begin
                tests_failed++; $display("FAIL full[%0d]: got high %0d lead %0d len %0d want 4 4 10", i, meas_hi[i], meas_lead[i], meas_len[i]);
            end
        end
    endtask

    task automatic test_random();
        int cur;
        int last;
        bit pend;
        int wraps;
        int guard;
        logic wr;
        logic [W-1:0] din;
        bit will_wrap;
        int got;
        spacing = $urandom_range(1, 4);
        div_cnt = 0;
        cur = $urandom_range(0, 12);
        step(1'b1, W'(cur), 1'b0);
        run_periods(2, 200);
        clear_meas();
        exp_q.delete();
        pend = 1'b0; last = 0; wraps = 0; guard = 0;
        while (wraps < 8 && guard < 2000) begin
            wr = ($urandom_range(0, 9) == 0);
            din = W'($urandom_range(0, 15));
            will_wrap = ((tick_total % P) == P - 1) && (div_cnt == spacing - 1);
            step(wr, din, 1'b0);
            if (wr) begin last = din; pend = 1'b1; end
            if (will_wrap) begin
                exp_q.push_back(16'(((cur > P) ? P : cur) * spacing));
                if (pend) cur = last;
                pend = 1'b0;
                wraps++;
            end
            guard++;
        end
        tests_run++; if (meas_hi.size() != exp_q.size() || wraps != 8) begin
            tests_failed++; $display("FAIL rand_count: got %0d periods want %0d", meas_hi.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && meas_hi.size() > 0) begin
            got = meas_hi.pop_front();
            tests_run++; if (got != int'(exp_q[0]) || meas_len.pop_front() != P * spacing) begin
                tests_failed++; $display("FAIL rand_period sp=%0d: got high %0d want %0d", spacing, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_double_buffer();
        test_boundaries();
        test_collisions();
        test_reset_fullrate();
        repeat (3) test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tick_pwm.md
Name: tick_pwm

Overview:
- Downstream consumer of the divider strobes: takes a one-cycle tick (e.g. a divide-by-5 pulse) and produces a PWM waveform whose period and duty are counted in ticks.
- Duty writes are double-buffered. They take effect only at a period boundary, so no glitched or truncated pulses appear.
- Emits a period-start strobe for the next stage.

Parameters:
- WIDTH, 8: width of the phase counter and duty registers.
- PERIOD, 10: ticks per PWM period. Legal range 2 .. 2^WIDTH-1. Elaboration check fails outside this range.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  advance strobe; one phase step per clk cycle in which it is high.
- duty_in  input  WIDTH  requested high time, in ticks.
- duty_wr  input  1  capture duty_in into the shadow register this cycle.
- duty_ack  output  1  one-cycle pulse, the cycle after any accepted duty_wr.
- pending  output  1  shadow holds a value not yet applied.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse, the cycle after the phase counter wraps to 0.

Behaviour:
- Reset (synchronous, has priority over everything): cnt=0, duty_act=0, duty_sh=0, pending=0, pwm_out=0, duty_ack=0, period_start=0.
- Reset mid-period aborts the period and discards any pending write.
- Phase counter cnt (WIDTH bits):
  - If tick_in=1 and cnt==PERIOD-1, cnt becomes 0 (the wrap event).
  - Else if tick_in=1, cnt becomes cnt+1.
  - Otherwise cnt holds.
- Shadow write: duty_wr=1 loads duty_sh with duty_in, sets pending=1, and pulses duty_ack=1 next cycle.
  - A write while pending=1 overwrites duty_sh; the last write wins.
  - duty_wr is never blocked.
- Clamp: the value applied to duty_act is min(value, PERIOD). Any duty >= PERIOD means 100%.
- On a wrap event:
  - If pending=1, duty_act becomes clamp(duty_sh) and pending clears.
  - period_start=1 the following cycle.
- Simultaneous duty_wr and wrap event: duty_in bypasses the shadow.
  - duty_act becomes clamp(duty_in) at this boundary.
  - pending ends at 0 and duty_ack still pulses.
- Without a wrap, duty_act never changes.
- pwm_out is registered: pwm_out(t+1) = (cnt(t) < duty_act(t)).
  - pwm_out lags the counter state by exactly 1 clk.
  - duty_act=0 gives pwm_out constantly 0.
  - duty_act=PERIOD gives pwm_out constantly 1, with no single-cycle dips at the wrap.
- tick_in high every cycle is legal (full-rate operation).
- tick_in low holds all state; pwm_out keeps its level.
- After reset, duty_act=0, so the output is low until the first write has been applied at a wrap.
- Width rules:
  - Comparisons are unsigned.
  - cnt never exceeds PERIOD-1.
  - No arithmetic overflow is possible because PERIOD <= 2^WIDTH-1.

Test Plan:
- Basic duty:
  - Stimulus: PERIOD=10, tick_in every 5th clk. Write duty=3 and let the first wrap apply it.
  - Response: pwm_out high 15 clk, low 35 clk, repeating. period_start pulses every 50 clk, one cycle after the cnt 9→0 transition.
- Double-buffering:
  - Stimulus: write duty=7 while cnt=4 in a period running at duty=3.
  - Response: current period stays 3 high ticks. pending=1 until the wrap. The next period shows 7 high ticks. duty_ack pulses once, 1 clk after the write.
- Boundaries:
  - duty=0 → pwm_out stays 0 for a full period.
  - duty=10 and duty=255 → pwm_out stays 1 continuously, including across the wrap.
  - duty=1 → exactly 1 tick high per period.
- Collisions:
  - Two writes (5, then 8) in one period → 8 applied at the wrap.
  - duty_wr=1 with duty_in=2 on the exact wrap cycle → the next period has 2 high ticks and pending=0.
- Reset and full-rate:
  - Stimulus: assert reset at cnt=6 with pending=1.
  - Response: next cycle all outputs are 0, cnt=0 and the pending write is lost.
  - Then with tick_in held high, PERIOD=10 and duty=4 → pwm_out pattern is 4 high, 6 low, repeating every 10 clk.
